// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and external memory handshakes around the shared memory port.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifReady;
  logic [31:0] ifData;

  logic        lsReq;
  logic        lsWrite;
  logic [31:0] lsAddr;
  logic [31:0] lsWData;
  logic [1:0]  storeCtrl;
  logic [2:0]  loadCtrl;
  logic        lsReady;
  logic [31:0] lsRData;
  logic        lsMisaligned;

  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memByteEn;
  logic        memAck;
  logic [31:0] memRData;

  modport slave (
    input  ifReq, ifAddr,
    output ifReady, ifData,
    input  lsReq, lsWrite, lsAddr, lsWData, storeCtrl, loadCtrl,
    output lsReady, lsRData, lsMisaligned,
    output memReq, memWrite, memAddr, memWData, memByteEn,
    input  memAck, memRData
  );

  modport master (
    output ifReq, ifAddr,
    input  ifReady, ifData,
    output lsReq, lsWrite, lsAddr, lsWData, storeCtrl, loadCtrl,
    input  lsReady, lsRData, lsMisaligned,
    input  memReq, memWrite, memAddr, memWData, memByteEn,
    output memAck, memRData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store, with starvation
// protection for fetch, lane steering for stores and sign/zero extension for loads.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyLs, StResp} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_ready_q, ls_ready_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        ls_mis_q, ls_mis_d;
  size_e       ld_size_q, ld_size_d;
  logic        ld_signed_q, ld_signed_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        ls_write_q, ls_write_d;

  // Decode of the pending load/store request.
  size_e       ls_size;
  logic        ls_signed;
  logic [1:0]  ls_off;
  logic        ls_misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    ls_size   = SzWord;
    ls_signed = 1'b0;
    st_be     = 4'b1111;
    st_wdata  = bus.lsWData;
    ls_off    = bus.lsAddr[1:0];
    if (bus.lsWrite) begin
      case (bus.storeCtrl)
        2'b00: begin
          ls_size  = SzByte;
          st_be    = 4'b0001 << ls_off;
          st_wdata = {4{bus.lsWData[7:0]}};
        end
        2'b01: begin
          ls_size  = SzHalf;
          st_be    = 4'b0011 << ls_off;
          st_wdata = {2{bus.lsWData[15:0]}};
        end
        default: ls_size = SzWord;
      endcase
    end else begin
      case (bus.loadCtrl)
        3'b000: begin
          ls_size   = SzByte;
          ls_signed = 1'b1;
        end
        3'b001: begin
          ls_size   = SzHalf;
          ls_signed = 1'b1;
        end
        3'b100:  ls_size = SzByte;
        3'b101:  ls_size = SzHalf;
        default: ls_size = SzWord;
      endcase
    end
    ls_misaligned = ((ls_size == SzHalf) && ls_off[0]) ||
                    ((ls_size == SzWord) && (ls_off != 2'b00));
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  logic [31:0] rd_shifted;
  logic [31:0] load_data;

  always_comb begin
    rd_shifted = bus.memRData >> {ld_off_q, 3'b000};
    case (ld_size_q)
      SzByte: load_data = ld_signed_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                      : {24'h0, rd_shifted[7:0]};
      SzHalf: load_data = ld_signed_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                      : {16'h0, rd_shifted[15:0]};
      default: load_data = bus.memRData;
    endcase
  end

  // Starved fetch pre-empts an otherwise winning load/store.
  logic starve_hit;
  logic grant_ls;
  logic grant_if;

  assign starve_hit = (starve_q == StarveMax) && bus.ifReq;
  assign grant_ls   = (state_q == StIdle) && bus.lsReq && !starve_hit;
  assign grant_if   = (state_q == StIdle) && bus.ifReq && !grant_ls;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ready_d  = 1'b0;
    if_data_d   = if_data_q;
    ls_ready_d  = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    ls_mis_d    = ls_mis_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    ld_off_d    = ld_off_q;
    ls_write_d  = ls_write_q;

    case (state_q)
      StIdle: begin
        if (!bus.ifReq) starve_d = 4'd0;
        if (grant_ls) begin
          if (bus.ifReq && (starve_q != StarveMax)) starve_d = starve_q + 4'd1;
          ld_size_d   = ls_size;
          ld_signed_d = ls_signed;
          ld_off_d    = ls_off;
          ls_write_d  = bus.lsWrite;
          if (ls_misaligned) begin
            // Rejected without touching memory; answer straight from IDLE.
            state_d    = StResp;
            ls_ready_d = 1'b1;
            ls_mis_d   = 1'b1;
            ls_rdata_d = 32'h0;
          end else begin
            state_d     = StBusyLs;
            mem_req_d   = 1'b1;
            mem_write_d = bus.lsWrite;
            mem_addr_d  = bus.lsAddr & 32'hFFFF_FFFC;
            mem_wdata_d = bus.lsWrite ? st_wdata : 32'h0;
            mem_be_d    = bus.lsWrite ? st_be : 4'b0000;
          end
        end else if (grant_if) begin
          starve_d    = 4'd0;
          state_d     = StBusyIf;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = bus.ifAddr & 32'hFFFF_FFFC;
          mem_wdata_d = 32'h0;
          mem_be_d    = 4'b0000;
        end
      end
      StBusyIf: begin
        if (bus.memAck) begin
          state_d     = StResp;
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          mem_be_d    = 4'b0000;
          if_ready_d  = 1'b1;
          if_data_d   = bus.memRData;
        end
      end
      StBusyLs: begin
        if (bus.memAck) begin
          state_d     = StResp;
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          mem_be_d    = 4'b0000;
          ls_ready_d  = 1'b1;
          ls_mis_d    = 1'b0;
          ls_rdata_d  = ls_write_q ? 32'h0 : load_data;
        end
      end
      default: begin
        state_d  = StIdle;
        ls_mis_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      if_ready_q  <= 1'b0;
      if_data_q   <= 32'h0;
      ls_ready_q  <= 1'b0;
      ls_rdata_q  <= 32'h0;
      ls_mis_q    <= 1'b0;
      ld_size_q   <= SzWord;
      ld_signed_q <= 1'b0;
      ld_off_q    <= 2'b00;
      ls_write_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ready_q  <= if_ready_d;
      if_data_q   <= if_data_d;
      ls_ready_q  <= ls_ready_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_mis_q    <= ls_mis_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      ld_off_q    <= ld_off_d;
      ls_write_q  <= ls_write_d;
    end
  end

  assign bus.memReq       = mem_req_q;
  assign bus.memWrite     = mem_write_q;
  assign bus.memAddr      = mem_addr_q;
  assign bus.memWData     = mem_wdata_q;
  assign bus.memByteEn    = mem_be_q;
  assign bus.ifReady      = if_ready_q;
  assign bus.ifData       = if_data_q;
  assign bus.lsReady      = ls_ready_q;
  assign bus.lsRData      = ls_rdata_q;
  assign bus.lsMisaligned = ls_mis_q;

endmodule
